pair_entry_scatter: RTL

Inbound counterpart of the pair exit path. It accepts a stream of 194-bit pair beats from the host-side init/AXIS logic. Each beat carries two 97-bit slots, each a valid bit plus a 96-bit particle record. The block delivers every valid record to its destination cell's input register, visiting cells in round-robin pair slots 0..SLOTS-1. It sits between `init_axis` (k2pc path) and the `N_CELL` cell position caches, and buffers beats in a small FIFO so that host bursts survive cell backpressure.

---
 rtl/md_pkg.sv | 29 ++
 rtl/beat_fifo.sv | 60 ++++++
 rtl/pair_entry_scatter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared particle-record constants and pair beat types
package md_pkg;

    localparam int DATA_W = 96;
    localparam int N_CELL = 27;
    localparam int SLOTS  = (N_CELL + 2) / 2;
    localparam int BEAT_W = 2 * DATA_W + 2;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } cell_entry_t;

    typedef struct packed {
        cell_entry_t e1;
        cell_entry_t e0;
    } pair_beat_t;

    // Wire packing is {v1, v0, d1, d0}; regroup into per-entry records.
    function automatic pair_beat_t unpack_beat(input logic [BEAT_W-1:0] raw);
        pair_beat_t b;
        b.e0.valid = raw[2*DATA_W];
        b.e1.valid = raw[2*DATA_W+1];
        b.e0.data  = raw[DATA_W-1:0];
        b.e1.data  = raw[2*DATA_W-1:DATA_W];
        return b;
    endfunction

endpackage

// File: rtl/beat_fifo.sv
// rtl/beat_fifo.sv - synchronous FIFO with registered count and full/empty flags
module beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: reads are only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pair_entry_scatter.sv
// rtl/pair_entry_scatter.sv - scatter buffered pair beats into per-cell input registers
module pair_entry_scatter #(
    parameter  int N_CELL     = md_pkg::N_CELL,
    parameter  int DATA_W     = md_pkg::DATA_W,
    parameter  int FIFO_DEPTH = 16,
    localparam int SLOTS      = (N_CELL + 2) / 2,
    localparam int SLOT_W     = $clog2(SLOTS),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int BEAT_W     = 2 * DATA_W + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_tvalid,
    input  logic [BEAT_W-1:0]        s_tdata,
    output logic                     s_tready,
    input  logic                     i_flush,
    output logic [N_CELL-1:0]        o_cell_valid,
    output logic [DATA_W*N_CELL-1:0] o_cell_data,
    input  logic [N_CELL-1:0]        i_cell_ready,
    output logic [SLOT_W-1:0]        o_slot,
    output logic                     o_sweep_done,
    output logic [CNT_W-1:0]         o_fifo_count
);

    localparam int IDX_W = SLOT_W + 1;

    logic [BEAT_W-1:0] head;
    logic              head_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              v0;
    logic              v1;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [IDX_W-1:0]  idx0;
    logic [IDX_W-1:0]  idx1;
    logic              need0;
    logic              need1;
    logic              free0;
    logic              free1;
    logic              last_slot;
    logic [N_CELL-1:0] cell_free;
    logic [N_CELL-1:0] load0;
    logic [N_CELL-1:0] load1;

    beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (i_flush),
        .push      (s_tvalid),
        .push_data (s_tdata),
        .pop       (head_pop),
        .pop_data  (head),
        .count     (o_fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign s_tready  = !fifo_full;

    assign d0        = head[DATA_W-1:0];
    assign d1        = head[2*DATA_W-1:DATA_W];
    assign v0        = head[2*DATA_W];
    assign v1        = head[2*DATA_W+1];

    assign idx0      = {o_slot, 1'b0};
    assign idx1      = {o_slot, 1'b1};
    assign need0     = v0 && (idx0 < IDX_W'(N_CELL));
    assign need1     = v1 && (idx1 < IDX_W'(N_CELL));
    assign last_slot = (o_slot == SLOT_W'(SLOTS - 1));

    // A register already being drained this cycle can take a new record.
    assign cell_free = ~o_cell_valid | i_cell_ready;

    // Both entries must find a free register before the head may leave.
    assign head_pop  = !fifo_empty && (!need0 || free0) && (!need1 || free1);

    // Look up the two addressed registers and build per-cell load strobes.
    always_comb begin
        free0 = 1'b1;
        free1 = 1'b1;
        load0 = '0;
        load1 = '0;
        for (int c = 0; c < N_CELL; c++) begin
            if (idx0 == IDX_W'(c)) begin
                free0    = cell_free[c];
                load0[c] = head_pop && need0;
            end
            if (idx1 == IDX_W'(c)) begin
                free1    = cell_free[c];
                load1[c] = head_pop && need1;
            end
        end
    end

    // Cell input registers: load wins over consume, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            o_cell_valid <= '0;
            o_cell_data  <= '0;
        end else begin
            for (int c = 0; c < N_CELL; c++) begin
                if (load0[c]) begin
                    o_cell_valid[c]                 <= 1'b1;
                    o_cell_data[DATA_W*c +: DATA_W] <= d0;
                end else if (load1[c]) begin
                    o_cell_valid[c]                 <= 1'b1;
                    o_cell_data[DATA_W*c +: DATA_W] <= d1;
                end else if (i_cell_ready[c]) begin
                    o_cell_valid[c]                 <= 1'b0;
                end
            end
        end
    end

    // Slot counter advances on every pop; the sentinel pop raises a one-cycle done.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            o_slot       <= '0;
            o_sweep_done <= 1'b0;
        end else begin
            o_sweep_done <= head_pop && last_slot && v1;
            if (head_pop) begin
                o_slot <= last_slot ? '0 : o_slot + 1'b1;
            end
        end
    end

endmodule
